// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer.
// The state enum, opcode values, register-file write-source encodings and
// the branch-offset sign extension live here.
package seq_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_HALT   = 3'd4,
        ST_TRAP   = 3'd5
    } seq_state_t;

    // Opcodes 0x0-0x7 are ALU operations; alu_op carries the low three bits.
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_BRZ  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_LI   = 4'hC;
    localparam logic [3:0] OP_ILL0 = 4'hD;
    localparam logic [3:0] OP_ILL1 = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Register-file write source select.
    localparam logic [1:0] WSEL_ALU = 2'd0;
    localparam logic [1:0] WSEL_MEM = 2'd1;
    localparam logic [1:0] WSEL_IMM = 2'd2;

    // Branch offsets are signed 8-bit values added to a 16-bit pc.
    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational opcode classifier for the instruction sequencer.
// Exactly one class flag is high for any opcode value.
module seq_decode
    import seq_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       is_alu,
    output logic       is_ld,
    output logic       is_st,
    output logic       is_br,
    output logic       is_jmp,
    output logic       is_li,
    output logic       is_halt,
    output logic       is_illegal
);

    // Classify the opcode; the ALU group is every opcode with the top bit clear.
    always_comb begin
        is_alu     = 1'b0;
        is_ld      = 1'b0;
        is_st      = 1'b0;
        is_br      = 1'b0;
        is_jmp     = 1'b0;
        is_li      = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        if (!opcode[3]) begin
            is_alu = 1'b1;
        end else begin
            case (opcode)
                OP_LD:   is_ld      = 1'b1;
                OP_ST:   is_st      = 1'b1;
                OP_BRZ:  is_br      = 1'b1;
                OP_JMP:  is_jmp     = 1'b1;
                OP_LI:   is_li      = 1'b1;
                OP_HALT: is_halt    = 1'b1;
                default: is_illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control unit for the 16-bit RISC core.
// Fetches over a req/ack instruction port into a private IR, decodes it into
// register selects and datapath strobes, and owns pc and the zero flag.
// Build option: define SEQ_TRAP_EN to trap opcodes 0xD/0xE (illegal held,
// all requests stop until reset); otherwise they execute as a 2-cycle NOP.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_FETCH  | imem_req high; on ack load IR, pc+1
// ST_DECODE | one cycle, selects stable, choose next phase
// ST_EXEC   | one cycle: ALU/LI write-back, BRZ/JMP pc update
// ST_MEM    | dmem_req high until ack; LD writes back on ack
// ST_HALT   | halted high, no requests; left only by reset
// ST_TRAP   | illegal high, no requests; left only by reset
module instr_sequencer
    import seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic [3:0]  DR,
    output logic [3:0]  SA,
    output logic [3:0]  SB,
    output logic [2:0]  alu_op,
    input  logic        alu_zero,
    output logic        rf_we,
    output logic [1:0]  rf_wsel,
    output logic [7:0]  imm8,
    output logic [15:0] pc,
    output logic        halted,
    output logic        illegal
);

    seq_state_t  state;
    seq_state_t  state_nxt;
    logic [15:0] ir;
    logic [15:0] pc_nxt;
    logic        z;
    logic        z_nxt;
    logic        ir_load;
    logic        fetch_active;

    logic is_alu;
    logic is_ld;
    logic is_st;
    logic is_br;
    logic is_jmp;
    logic is_li;
    logic is_halt;
    logic is_illegal;

    seq_decode u_decode (
        .opcode     (ir[15:12]),
        .is_alu     (is_alu),
        .is_ld      (is_ld),
        .is_st      (is_st),
        .is_br      (is_br),
        .is_jmp     (is_jmp),
        .is_li      (is_li),
        .is_halt    (is_halt),
        .is_illegal (is_illegal)
    );

    // Field selects come straight from the IR so they hold for the whole instruction.
    assign DR        = ir[11:8];
    assign SA        = ir[7:4];
    assign SB        = ir[3:0];
    assign alu_op    = ir[14:12];
    assign imm8      = ir[7:0];
    assign imem_addr = pc;

    // The reset value of state is FETCH, so gate the request with rst_n to
    // keep it low (and drop it asynchronously) while reset is asserted.
    assign imem_req = fetch_active & rst_n;

`ifdef SEQ_TRAP_EN
    assign illegal = (state == ST_TRAP);
`else
    assign illegal = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Architectural registers: instruction latch, program counter, zero flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir <= 16'h0000;
            pc <= 16'h0000;
            z  <= 1'b0;
        end else begin
            if (ir_load) begin
                ir <= imem_rdata;
            end
            pc <= pc_nxt;
            z  <= z_nxt;
        end
    end

    // Next-state, register updates and strobes; requests depend on state only,
    // the LD write-back strobe is qualified by dmem_ack inside ST_MEM.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        z_nxt        = z;
        ir_load      = 1'b0;
        fetch_active = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        rf_we        = 1'b0;
        rf_wsel      = WSEL_ALU;
        halted       = 1'b0;
        case (state)
            ST_FETCH: begin
                fetch_active = 1'b1;
                if (imem_ack) begin
                    ir_load   = 1'b1;
                    pc_nxt    = pc + 16'd1;
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (is_ld || is_st) begin
                    state_nxt = ST_MEM;
                end else if (is_halt) begin
                    state_nxt = ST_HALT;
                end else if (is_illegal) begin
`ifdef SEQ_TRAP_EN
                    state_nxt = ST_TRAP;
`else
                    state_nxt = ST_FETCH;
`endif
                end else begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_nxt = ST_FETCH;
                if (is_alu) begin
                    rf_we   = 1'b1;
                    rf_wsel = WSEL_ALU;
                    z_nxt   = alu_zero;
                end else if (is_li) begin
                    rf_we   = 1'b1;
                    rf_wsel = WSEL_IMM;
                end else if (is_jmp || (is_br && z)) begin
                    // pc already points past the branch, so the offset is relative to pc+1.
                    pc_nxt = pc + sext8(ir[7:0]);
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_st;
                if (dmem_ack) begin
                    if (is_ld) begin
                        rf_we   = 1'b1;
                        rf_wsel = WSEL_MEM;
                    end
                    state_nxt = ST_FETCH;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            ST_TRAP: begin
                state_nxt = ST_TRAP;
            end
            default: begin
                state_nxt = ST_FETCH;
            end
        endcase
    end

endmodule
